// File: rtl/ts_pkg.sv
// ts_pkg: shared width helpers, serializer state encoding
// and line levels for the multichannel timestamp capture block.
package ts_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } ser_state_e;

   localparam logic IDLE_LVL = 1'b1;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Channel id width, never below one bit.
   function automatic int ch_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   function automatic int frame_width(input int n, input int tsw);
      return ch_width(n) + tsw;
   endfunction

endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: first-word-fall-through event FIFO.
// Ports: clk, rstn (async low), push/din, pop/dout, full, empty, level.
module ts_fifo
   import ts_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(DEPTH):0]  level
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_q, wr_d;
   logic [AW-1:0]               rd_q, rd_d;
   logic [LW-1:0]               lvl_q, lvl_d;
   logic                        push_ok;
   logic                        pop_ok;

   assign full    = (lvl_q == LW'(DEPTH));
   assign empty   = (lvl_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem_q[rd_q];
   assign level   = lvl_q;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (push_ok) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_d = rd_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
         lvl_d = lvl_q + LW'(1);
      end else if (pop_ok && !push_ok) begin
         lvl_d = lvl_q - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

endmodule

// File: rtl/ts_multichan_capture.sv
// ts_multichan_capture: sync + edge-detect NUM_CH inputs, timestamp,
// queue, and ship {ch_id, ts} frames out as UART-style serial.
// Ports: clk, rstn (async low), datain, ovf_clr -> serialout,
// overflow (sticky drop flag), fifo_level.
module ts_multichan_capture
   import ts_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int TS_WIDTH   = 24,
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD_DIV   = 16
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [NUM_CH-1:0]           datain,
   input  logic                        ovf_clr,
   output logic                        serialout,
   output logic                        overflow,
   output logic [clog2(FIFO_DEPTH):0]  fifo_level
);

   localparam int CH_W    = ch_width(NUM_CH);
   localparam int FRAME_W = frame_width(NUM_CH, TS_WIDTH);
   localparam int BD_W    = clog2(BAUD_DIV);
   localparam int BIT_W   = clog2(FRAME_W + 1);

   localparam logic [BD_W-1:0]  BAUD_LAST = BD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

   logic [TS_WIDTH-1:0]             counter_q, counter_d;
   logic [NUM_CH-1:0]               sync1_q, sync2_q, prev_q;
   logic [NUM_CH-1:0]               detect;
   logic [NUM_CH-1:0]               pend_v_q, pend_v_d;
   logic [NUM_CH-1:0][TS_WIDTH-1:0] pend_ts_q, pend_ts_d;
   logic [NUM_CH-1:0]               grant;
   logic                            drop;
   logic                            ovf_q, ovf_d;

   logic                            fifo_push;
   logic [FRAME_W-1:0]              fifo_din;
   logic                            fifo_pop;
   logic [FRAME_W-1:0]              fifo_dout;
   logic                            fifo_full;
   logic                            fifo_empty;

   ser_state_e                      state_q, state_d;
   logic [BD_W-1:0]                 baud_q, baud_d;
   logic [BIT_W-1:0]                bit_q, bit_d;
   logic [FRAME_W-1:0]              shreg_q, shreg_d;
   logic                            ser_q, ser_d;
   logic                            baud_end;

   assign counter_d = counter_q + TS_WIDTH'(1);
   assign detect    = sync2_q & ~prev_q;

   // Descending scan so the lowest valid index wins.
   always_comb begin
      grant     = '0;
      fifo_push = 1'b0;
      fifo_din  = '0;
      if (!fifo_full) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_v_q[i]) begin
               grant     = '0;
               grant[i]  = 1'b1;
               fifo_push = 1'b1;
               fifo_din  = {CH_W'(i), pend_ts_q[i]};
            end
         end
      end
   end

   // A slot draining this cycle may accept a new edge.
   always_comb begin
      pend_v_d  = pend_v_q;
      pend_ts_d = pend_ts_q;
      drop      = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (detect[i]) begin
            if (!pend_v_q[i] || grant[i]) begin
               pend_v_d[i]  = 1'b1;
               pend_ts_d[i] = counter_q;
            end else begin
               drop = 1'b1;
            end
         end else if (grant[i]) begin
            pend_v_d[i] = 1'b0;
         end
      end
      ovf_d = (ovf_q & ~ovf_clr) | drop;
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      fifo_pop = 1'b0;
      baud_end = (baud_q == BAUD_LAST);
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shreg_d  = fifo_dout;
               baud_d   = '0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BD_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
               end
            end else begin
               baud_d = baud_q + BD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shreg_d  = fifo_dout;
                  state_d  = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + BD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Line level follows the state being entered.
      unique case (state_d)
         ST_START: ser_d = 1'b0;
         ST_DATA:  ser_d = shreg_d[FRAME_W-1];
         default:  ser_d = IDLE_LVL;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         counter_q <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         pend_v_q  <= '0;
         pend_ts_q <= '0;
         ovf_q     <= 1'b0;
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         ser_q     <= IDLE_LVL;
      end else begin
         counter_q <= counter_d;
         sync1_q   <= datain;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         pend_v_q  <= pend_v_d;
         pend_ts_q <= pend_ts_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         ser_q     <= ser_d;
      end
   end

   ts_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign serialout = ser_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_ts_multichan_capture.sv
// tb_ts_multichan_capture: directed checks of capture, queueing,
// overflow and serial framing for default and 8-bit-ts builds.
module tb_ts_multichan_capture;

   localparam int BD = 16;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  datain;
   logic        ovf_clr;
   logic        serialout;
   logic        overflow;
   logic [3:0]  fifo_level;

   logic [3:0]  datain8;
   logic        ovf_clr8;
   logic        serial8;
   logic        overflow8;
   logic [3:0]  level8;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [23:0] tb_cnt;

   always #5 clk = ~clk;

   // Bench copy of the free-running counter.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) tb_cnt <= '0;
      else       tb_cnt <= tb_cnt + 24'd1;
   end

   ts_multichan_capture dut (
      .clk        (clk),
      .rstn       (rstn),
      .datain     (datain),
      .ovf_clr    (ovf_clr),
      .serialout  (serialout),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   ts_multichan_capture #(.TS_WIDTH(8)) dut8 (
      .clk        (clk),
      .rstn       (rstn),
      .datain     (datain8),
      .ovf_clr    (ovf_clr8),
      .serialout  (serial8),
      .overflow   (overflow8),
      .fifo_level (level8)
   );

   function automatic logic line_of(input bit sel);
      return sel ? serial8 : serialout;
   endfunction

   task automatic wait_cnt(input int t);
      int n;
      n = 0;
      while (tb_cnt != 24'(t) && n < 20000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic do_reset();
      rstn     = 1'b0;
      datain   = '0;
      datain8  = '0;
      ovf_clr  = 1'b0;
      ovf_clr8 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic get_frame(input bit sel, input int nbits, input int tmo,
                            output logic [31:0] val, output int gap,
                            output bit ok);
      bit seen;
      val  = '0;
      gap  = 0;
      ok   = 1'b0;
      seen = 1'b0;
      while (!seen && gap < tmo) begin
         @(negedge clk);
         gap++;
         seen = (line_of(sel) == 1'b0);
      end
      if (seen) begin
         repeat (BD/2) @(negedge clk);
         ok = (line_of(sel) == 1'b0);
         for (int i = 0; i < nbits; i++) begin
            repeat (BD) @(negedge clk);
            val = {val[30:0], line_of(sel)};
         end
         repeat (BD) @(negedge clk);
         ok = ok && (line_of(sel) == 1'b1);
      end
   endtask

   task automatic count_lows(input bit sel, input int n, output int lows);
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (line_of(sel) == 1'b0) lows++;
      end
   endtask

   task automatic test_reset();
      rstn     = 1'b0;
      datain   = '0;
      datain8  = '0;
      ovf_clr  = 1'b0;
      ovf_clr8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (serialout !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_serial: got %b expected 1", serialout);
      end
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovf: got %b expected 0", overflow);
      end
      n_checks++;
      if (fifo_level !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_level: got %0d expected 0", fifo_level);
      end
      n_checks++;
      if (serial8 !== 1'b1 || level8 !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_dut8: got ser=%b lvl=%0d expected 1/0",
                  serial8, level8);
      end
      rstn = 1'b1;
   endtask

   task automatic test_single();
      logic [31:0] val;
      int gap, lows;
      bit ok;
      do_reset();
      wait_cnt(100);
      datain = 4'b0100;
      repeat (3) @(posedge clk);
      #1 datain = '0;
      get_frame(1'b0, 26, 1000, val, gap, ok);
      n_checks++;
      if (!ok || val !== {6'd0, 2'd2, 24'd102}) begin
         n_fail++;
         $display("FAIL single_frame: got %h ok=%b expected %h",
                  val, ok, {6'd0, 2'd2, 24'd102});
      end
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ovf: got %b expected 0", overflow);
      end
      count_lows(1'b0, 100, lows);
      n_checks++;
      if (lows != 0) begin
         n_fail++;
         $display("FAIL single_idle: got %0d low samples expected 0", lows);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] val;
      int gap;
      bit ok;
      do_reset();
      wait_cnt(500);
      datain = 4'b1010;
      repeat (3) @(posedge clk);
      #1 datain = '0;
      get_frame(1'b0, 26, 1000, val, gap, ok);
      n_checks++;
      if (!ok || val !== {6'd0, 2'd1, 24'd502}) begin
         n_fail++;
         $display("FAIL simul_first: got %h ok=%b expected %h",
                  val, ok, {6'd0, 2'd1, 24'd502});
      end
      get_frame(1'b0, 26, 1000, val, gap, ok);
      n_checks++;
      if (!ok || val !== {6'd0, 2'd3, 24'd502}) begin
         n_fail++;
         $display("FAIL simul_second: got %h ok=%b expected %h",
                  val, ok, {6'd0, 2'd3, 24'd502});
      end
      n_checks++;
      if (gap != BD/2) begin
         n_fail++;
         $display("FAIL simul_gap: got %0d expected %0d", gap, BD/2);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] val;
      int gap;
      bit ok;
      do_reset();
      wait_cnt(254);
      datain8 = 4'b0001;
      repeat (2) @(posedge clk);
      #1 datain8 = '0;
      get_frame(1'b1, 10, 1000, val, gap, ok);
      n_checks++;
      if (!ok || val !== 32'h000) begin
         n_fail++;
         $display("FAIL wrap_first: got %h ok=%b expected 000", val, ok);
      end
      wait_cnt(522);
      datain8 = 4'b0001;
      repeat (2) @(posedge clk);
      #1 datain8 = '0;
      get_frame(1'b1, 10, 1000, val, gap, ok);
      n_checks++;
      if (!ok || val !== 32'h00C) begin
         n_fail++;
         $display("FAIL wrap_second: got %h ok=%b expected 00c", val, ok);
      end
   endtask

   task automatic test_overflow();
      int exp_ch [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 1, 2, 3};
      int exp_ts [13] = '{22, 22, 22, 22, 30, 30, 30, 30, 38,
                          46, 38, 38, 38};
      do_reset();
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               wait_cnt(20 + 8 * k);
               datain = 4'hF;
               @(posedge clk);
               #1 datain = '0;
            end
            wait_cnt(225);
            n_checks++;
            if (fifo_level !== 4'd8) begin
               n_fail++;
               $display("FAIL ovf_level: got %0d expected 8", fifo_level);
            end
            n_checks++;
            if (overflow !== 1'b1) begin
               n_fail++;
               $display("FAIL ovf_set: got %b expected 1", overflow);
            end
            wait_cnt(230);
            ovf_clr = 1'b1;
            @(posedge clk);
            #1 ovf_clr = 1'b0;
            n_checks++;
            if (overflow !== 1'b0) begin
               n_fail++;
               $display("FAIL ovf_clear: got %b expected 0", overflow);
            end
            wait_cnt(240);
            datain = 4'b0010;
            @(posedge clk);
            #1 datain = '0;
            @(posedge clk);
            #1 ovf_clr = 1'b1;
            @(posedge clk);
            #1 ovf_clr = 1'b0;
            n_checks++;
            if (overflow !== 1'b1) begin
               n_fail++;
               $display("FAIL ovf_set_wins: got %b expected 1", overflow);
            end
         end
         begin
            logic [31:0] val;
            logic [31:0] exp;
            int gap;
            bit ok;
            for (int f = 0; f < 13; f++) begin
               get_frame(1'b0, 26, 1000, val, gap, ok);
               exp = (32'(exp_ch[f]) << 24) | 32'(exp_ts[f]);
               n_checks++;
               if (!ok || val !== exp) begin
                  n_fail++;
                  $display("FAIL ovf_frame%0d: got %h ok=%b expected %h",
                           f, val, ok, exp);
               end
            end
         end
      join
      n_checks++;
      if (fifo_level !== 4'd0) begin
         n_fail++;
         $display("FAIL ovf_drained: got %0d expected 0", fifo_level);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] val;
      int gap, lows;
      bit ok;
      do_reset();
      wait_cnt(10);
      datain = 4'b1001;
      repeat (2) @(posedge clk);
      #1 datain = '0;
      wait_cnt(100);
      n_checks++;
      if (serialout !== 1'b0 || fifo_level !== 4'd1) begin
         n_fail++;
         $display("FAIL mid_before: got ser=%b lvl=%0d expected 0/1",
                  serialout, fifo_level);
      end
      rstn = 1'b0;
      #1;
      n_checks++;
      if (serialout !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_serial: got %b expected 1", serialout);
      end
      n_checks++;
      if (fifo_level !== 4'd0) begin
         n_fail++;
         $display("FAIL mid_level: got %0d expected 0", fifo_level);
      end
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      count_lows(1'b0, 600, lows);
      n_checks++;
      if (lows != 0) begin
         n_fail++;
         $display("FAIL mid_quiet: got %0d low samples expected 0", lows);
      end
      wait_cnt(700);
      datain = 4'b0100;
      repeat (2) @(posedge clk);
      #1 datain = '0;
      get_frame(1'b0, 26, 1000, val, gap, ok);
      n_checks++;
      if (!ok || val !== {6'd0, 2'd2, 24'd702}) begin
         n_fail++;
         $display("FAIL mid_after: got %h ok=%b expected %h",
                  val, ok, {6'd0, 2'd2, 24'd702});
      end
   endtask

   task automatic test_level_glitch();
      logic [31:0] val;
      int gap, lows;
      bit ok;
      do_reset();
      fork
         begin
            wait_cnt(50);
            datain = 4'b0001;
            repeat (1000) @(posedge clk);
            #1 datain = '0;
         end
         begin
            logic [31:0] v;
            int g, l;
            bit k;
            get_frame(1'b0, 26, 1000, v, g, k);
            n_checks++;
            if (!k || v !== {6'd0, 2'd0, 24'd52}) begin
               n_fail++;
               $display("FAIL level_frame: got %h ok=%b expected %h",
                        v, k, {6'd0, 2'd0, 24'd52});
            end
            count_lows(1'b0, 1200, l);
            n_checks++;
            if (l != 0) begin
               n_fail++;
               $display("FAIL level_single: got %0d low samples expected 0",
                        l);
            end
         end
      join
      wait_cnt(1800);
      datain = 4'b0001;
      @(posedge clk);
      #1 datain = '0;
      get_frame(1'b0, 26, 1000, val, gap, ok);
      n_checks++;
      if (!ok || val !== {6'd0, 2'd0, 24'd1802}) begin
         n_fail++;
         $display("FAIL glitch_frame: got %h ok=%b expected %h",
                  val, ok, {6'd0, 2'd0, 24'd1802});
      end
      count_lows(1'b0, 300, lows);
      n_checks++;
      if (lows != 0) begin
         n_fail++;
         $display("FAIL glitch_single: got %0d low samples expected 0", lows);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_wrap();
      test_overflow();
      test_reset_mid();
      test_level_glitch();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
